// File: rtl/ann_pkg.sv
// Shared constants, loader state encoding and patch record layout for the KD-tree loader.
package ann_pkg;
  localparam int DATA_WIDTH  = 11;
  localparam int IDX_WIDTH   = 9;
  localparam int PATCH_SIZE  = 5;
  localparam int LEAF_SIZE   = 8;
  localparam int NUM_LEAVES  = 64;
  localparam int NUM_NODES   = NUM_LEAVES - 1;
  localparam int NUM_QUERYS  = 494;
  localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES);
  localparam int SLOT_W      = $clog2(LEAF_SIZE);
  localparam int QUERY_ADDRW = $clog2(NUM_QUERYS);
  localparam int ELEM_CNTW   = $clog2(PATCH_SIZE + 1);
  localparam int PATCH_W     = IDX_WIDTH + PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, NODES, LEAVES, QUERY, DONE} loader_state_e;

  // elem[0] occupies the LSBs, idx the MSBs
  typedef struct packed {
    logic [IDX_WIDTH-1:0]                   idx;
    logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]  elem;
  } patch_t;
endpackage

// File: rtl/patch_assembler.sv
// Collects PATCH_SIZE element words (plus an optional trailing index word) into a patch.
// complete/patch are combinational on the final word; words only advance when word_vld is high.
module patch_assembler
  import ann_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  word_vld,
  input  logic [DATA_WIDTH-1:0] word_dat,
  input  logic                  with_idx,
  output logic                  complete,
  output patch_t                patch
);
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] elem_q;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] elem_shift;
  logic [ELEM_CNTW-1:0]                  cnt_q;
  logic [ELEM_CNTW-1:0]                  last_cnt;

  // newest word enters at the top so the first element ends up in elem[0]
  assign elem_shift = {word_dat, elem_q[PATCH_SIZE-1:1]};
  assign last_cnt   = with_idx ? ELEM_CNTW'(PATCH_SIZE) : ELEM_CNTW'(PATCH_SIZE - 1);
  assign complete   = word_vld && (cnt_q == last_cnt);

  always_comb begin
    patch      = '0;
    patch.elem = with_idx ? elem_q : elem_shift;
    patch.idx  = with_idx ? word_dat[IDX_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      elem_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      elem_q <= '0;
    end else if (word_vld) begin
      cnt_q <= complete ? '0 : cnt_q + 1'b1;
      if (cnt_q < ELEM_CNTW'(PATCH_SIZE))
        elem_q <= elem_shift;
    end
  end
endmodule

// File: rtl/input_stream_loader.sv
// Dequeues the node/leaf/query word stream after load_kdtree and issues record write strobes.
// Strobes arrive one cycle after the completing word; an empty FIFO stalls all counters.
module input_stream_loader
  import ann_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_kdtree,
  input  logic [DATA_WIDTH-1:0]             fifo_rdata,
  input  logic                              fifo_rempty_n,
  output logic                              fifo_deq,
  output logic                              busy,
  output logic                              load_done,
  output logic                              node_wen,
  output logic [LEAF_ADDRW-1:0]             node_addr,
  output logic [2:0]                        node_dim,
  output logic [DATA_WIDTH-1:0]             node_median,
  output logic                              leaf_wen,
  output logic [LEAF_ADDRW-1:0]             leaf_addr,
  output logic [SLOT_W-1:0]                 leaf_slot,
  output logic [PATCH_W-1:0]                leaf_wpatch,
  output logic                              query_wen,
  output logic [QUERY_ADDRW-1:0]            query_addr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]  query_wpatch
);
  loader_state_e state_q, state_d;

  logic                   node_phase_q;
  logic [2:0]             dim_q;
  logic [LEAF_ADDRW-1:0]  node_cnt_q, leaf_cnt_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [QUERY_ADDRW-1:0] query_cnt_q;
  logic                   node_vld, node_wr, node_last, leaf_last, query_last;
  logic                   asm_vld, asm_clear, asm_done, leaf_done, query_done;
  patch_t                 asm_patch;

  assign node_vld   = fifo_deq && (state_q == NODES);
  assign node_wr    = node_vld && node_phase_q;
  assign node_last  = node_phase_q && (node_cnt_q == LEAF_ADDRW'(NUM_NODES - 1));
  assign leaf_last  = (leaf_cnt_q == LEAF_ADDRW'(NUM_LEAVES - 1)) && (slot_q == SLOT_W'(LEAF_SIZE - 1));
  assign query_last = (query_cnt_q == QUERY_ADDRW'(NUM_QUERYS - 1));
  assign asm_vld    = fifo_deq && ((state_q == LEAVES) || (state_q == QUERY));
  assign asm_clear  = (state_q != state_d);
  assign leaf_done  = asm_done && (state_q == LEAVES);
  assign query_done = asm_done && (state_q == QUERY);

  patch_assembler u_patch_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .word_vld (asm_vld),
    .word_dat (fifo_rdata),
    .with_idx (state_q == LEAVES),
    .complete (asm_done),
    .patch    (asm_patch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_kdtree)             state_d = NODES;
      NODES:   if (node_vld && node_last)   state_d = LEAVES;
      LEAVES:  if (leaf_done && leaf_last)  state_d = QUERY;
      QUERY:   if (query_done && query_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_deq  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_q)
      NODES, LEAVES, QUERY: begin
        fifo_deq = fifo_rempty_n;
        busy     = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // counters saturate at their terminal record; IDLE re-arms them for the next image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_phase_q <= 1'b0;
      dim_q        <= '0;
      node_cnt_q   <= '0;
      leaf_cnt_q   <= '0;
      slot_q       <= '0;
      query_cnt_q  <= '0;
    end else if (state_q == IDLE) begin
      node_phase_q <= 1'b0;
      dim_q        <= '0;
      node_cnt_q   <= '0;
      leaf_cnt_q   <= '0;
      slot_q       <= '0;
      query_cnt_q  <= '0;
    end else begin
      if (node_vld) begin
        node_phase_q <= ~node_phase_q;
        if (!node_phase_q)  dim_q      <= fifo_rdata[2:0];
        else if (!node_last) node_cnt_q <= node_cnt_q + 1'b1;
      end
      if (leaf_done && !leaf_last) begin
        slot_q <= slot_q + 1'b1;
        if (slot_q == SLOT_W'(LEAF_SIZE - 1)) leaf_cnt_q <= leaf_cnt_q + 1'b1;
      end
      if (query_done && !query_last) query_cnt_q <= query_cnt_q + 1'b1;
    end
  end

  // data/address buses are zero whenever their strobe is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_wen     <= 1'b0;
      node_addr    <= '0;
      node_dim     <= '0;
      node_median  <= '0;
      leaf_wen     <= 1'b0;
      leaf_addr    <= '0;
      leaf_slot    <= '0;
      leaf_wpatch  <= '0;
      query_wen    <= 1'b0;
      query_addr   <= '0;
      query_wpatch <= '0;
    end else begin
      node_wen     <= node_wr;
      node_addr    <= node_wr ? node_cnt_q : '0;
      node_dim     <= node_wr ? dim_q : '0;
      node_median  <= node_wr ? fifo_rdata : '0;
      leaf_wen     <= leaf_done;
      leaf_addr    <= leaf_done ? leaf_cnt_q : '0;
      leaf_slot    <= leaf_done ? slot_q : '0;
      leaf_wpatch  <= leaf_done ? asm_patch : '0;
      query_wen    <= query_done;
      query_addr   <= query_done ? query_cnt_q : '0;
      query_wpatch <= query_done ? asm_patch.elem : '0;
    end
  end
endmodule

// File: tb/tb_input_stream_loader.sv
// Bench for input_stream_loader: FIFO stream model, write scoreboard, fixed data vectors, reset/restart sequences.
`timescale 1ns/1ps
module tb_input_stream_loader;
  import ann_pkg::*;

  localparam int N_NODE_W = 2 * NUM_NODES;
  localparam int N_LEAF_W = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
  localparam int N_QRY_W  = NUM_QUERYS * PATCH_SIZE;
  localparam int N_WORDS  = N_NODE_W + N_LEAF_W + N_QRY_W;
  localparam int NVEC     = 8;

  logic        clk, rst, load_kdtree, fifo_rempty_n, fifo_deq, busy, load_done;
  logic [10:0] fifo_rdata, node_median;
  logic [5:0]  node_addr, leaf_addr;
  logic [2:0]  node_dim, leaf_slot;
  logic [63:0] leaf_wpatch;
  logic        node_wen, leaf_wen, query_wen;
  logic [8:0]  query_addr;
  logic [54:0] query_wpatch;

  input_stream_loader dut (
    .clk(clk), .rst(rst), .load_kdtree(load_kdtree), .fifo_rdata(fifo_rdata),
    .fifo_rempty_n(fifo_rempty_n), .fifo_deq(fifo_deq), .busy(busy), .load_done(load_done),
    .node_wen(node_wen), .node_addr(node_addr), .node_dim(node_dim), .node_median(node_median),
    .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_slot(leaf_slot), .leaf_wpatch(leaf_wpatch),
    .query_wen(query_wen), .query_addr(query_addr), .query_wpatch(query_wpatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int slot; logic [63:0] dat; } rec_t;
  // w holds the stream words of one record, w[0] first on the stream
  typedef struct { int kind; int addr; int slot; logic [5:0][10:0] w; logic [63:0] exp_dat; } vec_t;

  int          n_chk, n_pass, n_fail;
  logic [10:0] words [N_WORDS];
  bit          exp_vld [N_WORDS];
  rec_t        exp_rec [N_WORDS];
  rec_t        sb [$];
  logic [63:0] obs_node [64];
  logic [63:0] obs_leaf [512];
  logic [63:0] obs_query [512];
  vec_t        vec [NVEC];

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [87:0] pack(input rec_t r);
    return {8'(r.kind), 12'(r.addr), 4'(r.slot), r.dat};
  endfunction

  task automatic build_image();
    int pos, nw, b;
    for (int i = 0; i < N_WORDS; i++) begin
      words[i]   = 11'($urandom_range(2047, 0));
      exp_vld[i] = 1'b0;
    end
    for (int v = 0; v < NVEC; v++) begin
      case (vec[v].kind)
        1:       begin pos = 2 * vec[v].addr; nw = 2; end
        2:       begin pos = N_NODE_W + (vec[v].addr * LEAF_SIZE + vec[v].slot) * 6; nw = 6; end
        default: begin pos = N_NODE_W + N_LEAF_W + vec[v].addr * 5; nw = 5; end
      endcase
      for (int k = 0; k < nw; k++) words[pos + k] = vec[v].w[k];
    end
    for (int n = 0; n < NUM_NODES; n++) begin
      exp_vld[2*n+1] = 1'b1;
      exp_rec[2*n+1] = '{1, n, 0, {50'd0, words[2*n][2:0], words[2*n+1]}};
    end
    for (int p = 0; p < NUM_LEAVES * LEAF_SIZE; p++) begin
      b = N_NODE_W + p * 6;
      exp_vld[b+5] = 1'b1;
      exp_rec[b+5] = '{2, p / 8, p % 8, {words[b+5][8:0], words[b+4], words[b+3],
                                         words[b+2], words[b+1], words[b]}};
    end
    for (int q = 0; q < NUM_QUERYS; q++) begin
      b = N_NODE_W + N_LEAF_W + q * 5;
      exp_vld[b+4] = 1'b1;
      exp_rec[b+4] = '{3, q, 0, {9'd0, words[b+4], words[b+3], words[b+2], words[b+1], words[b]}};
    end
  endtask

  task automatic check_table();
    logic [63:0] got;
    for (int v = 0; v < NVEC; v++) begin
      case (vec[v].kind)
        1:       got = obs_node[vec[v].addr];
        2:       got = obs_leaf[vec[v].addr * 8 + vec[v].slot];
        default: got = obs_query[vec[v].addr];
      endcase
      check($sformatf("vec%0d", v), got, vec[v].exp_dat);
    end
  endtask

  // Returns at #1 after a posedge, with the DUT back in IDLE (or held in reset then released).
  task automatic run_load(input int gap_pct, input int pre_idle, input bit extra_start, input int abort_at);
    int   ptr, it, deq_cnt, nn, nl, nq, nd, done_it, nstb;
    bit   extra_done;
    rec_t act, exp_r;
    ptr = 0; deq_cnt = 0; nn = 0; nl = 0; nq = 0; nd = 0; done_it = -1; extra_done = 1'b0;
    sb.delete();
    foreach (obs_node[i])  obs_node[i]  = '1;
    foreach (obs_leaf[i])  obs_leaf[i]  = '1;
    foreach (obs_query[i]) obs_query[i] = '1;
    for (int k = 0; k < pre_idle; k++) begin
      load_kdtree = 1'b0; fifo_rempty_n = 1'b1; fifo_rdata = words[0];
      #1;
      check("idle_no_deq", fifo_deq, 0);
      @(posedge clk); #1;
    end
    it = 0;
    while (1) begin
      nstb = int'(node_wen) + int'(leaf_wen) + int'(query_wen);
      if (nstb != 0) begin
        if (node_wen)      act = '{1, int'(node_addr), 0, {50'd0, node_dim, node_median}};
        else if (leaf_wen) act = '{2, int'(leaf_addr), int'(leaf_slot), leaf_wpatch};
        else               act = '{3, int'(query_addr), 0, {9'd0, query_wpatch}};
        if (nstb > 1) act.kind = 9;
        if (sb.size() == 0) check("unexpected_write", nstb, 0);
        else begin
          exp_r = sb.pop_front();
          check("write", pack(act), pack(exp_r));
        end
        case (act.kind)
          1: begin nn++; obs_node[act.addr] = act.dat; end
          2: begin nl++; obs_leaf[act.addr * 8 + act.slot] = act.dat; end
          3: begin nq++; obs_query[act.addr] = act.dat; end
          default: ;
        endcase
        if (act.kind == 3 && act.addr == NUM_QUERYS - 1) check("done_with_last_query", load_done, 1);
      end else if (sb.size() != 0) begin
        check("missing_write", nstb, 1);
        void'(sb.pop_front());
      end
      if (load_done) begin nd++; done_it = it; end
      if (it == 0) check("idle_busy", busy, 0);
      if (it == 1) check("start_busy", busy, 1);
      if (done_it >= 0) break;
      if (it > 20000) begin
        check("load_timeout", it, 0);
        break;
      end
      load_kdtree = (it == 0) || (extra_start && !extra_done && ptr == N_NODE_W + 500);
      if (load_kdtree && it != 0) extra_done = 1'b1;
      fifo_rempty_n = (ptr < N_WORDS) && ($urandom_range(99, 0) >= gap_pct);
      fifo_rdata = (ptr < N_WORDS) ? words[ptr] : 11'($urandom);
      #1;
      if (it == 0) check("start_cycle_no_deq", fifo_deq, 0);
      if (!fifo_rempty_n) check("deq_when_empty", fifo_deq, 0);
      if (fifo_deq && fifo_rempty_n) begin
        deq_cnt++;
        if (exp_vld[ptr]) sb.push_back(exp_rec[ptr]);
        ptr++;
      end
      if (abort_at >= 0 && ptr == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_deq", fifo_deq, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_strobes", {node_wen, leaf_wen, query_wen}, 0);
        check("rst_leaf_bus", {leaf_addr, leaf_slot, leaf_wpatch}, 0);
        sb.delete();
        load_kdtree = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      it++;
    end
    check("node_writes", nn, NUM_NODES);
    check("leaf_writes", nl, NUM_LEAVES * LEAF_SIZE);
    check("query_writes", nq, NUM_QUERYS);
    check("load_done_pulses", nd, 1);
    check("deq_count", deq_cnt, N_WORDS);
    check("scoreboard_drained", sb.size(), 0);
    if (gap_pct == 0) check("done_latency", done_it, N_WORDS + 1);
    load_kdtree = 1'b0;
    fifo_rempty_n = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    vec[0] = '{1, 5,  0, {44'd0, 11'd517, 11'd2},     {50'd0, 3'd2, 11'd517}};
    vec[1] = '{1, 0,  0, {44'd0, 11'd0, 11'h7FD},     {50'd0, 3'd5, 11'd0}};
    vec[2] = '{1, 62, 0, {44'd0, 11'd2047, 11'd7},    {50'd0, 3'd7, 11'd2047}};
    vec[3] = '{2, 63, 7, {11'd493, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1},
               {9'd493, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1}};
    vec[4] = '{2, 0,  0, {11'h7FF, 11'd2046, 11'd1, 11'd1024, 11'd0, 11'd2047},
               {9'h1FF, 11'd2046, 11'd1, 11'd1024, 11'd0, 11'd2047}};
    vec[5] = '{2, 1,  0, {11'h600, 11'd50, 11'd40, 11'd30, 11'd20, 11'd10},
               {9'd0, 11'd50, 11'd40, 11'd30, 11'd20, 11'd10}};
    vec[6] = '{3, 0,  0, {11'd0, 11'd500, 11'd400, 11'd300, 11'd200, 11'd100},
               {9'd0, 11'd500, 11'd400, 11'd300, 11'd200, 11'd100}};
    vec[7] = '{3, 493, 0, {11'd0, 11'd4, 11'd3, 11'd2, 11'd1, 11'd2047},
               {9'd0, 11'd4, 11'd3, 11'd2, 11'd1, 11'd2047}};

    rst = 1'b0; load_kdtree = 1'b0; fifo_rempty_n = 1'b1; fifo_rdata = 11'h155;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_deq", fifo_deq, 0);
    check("reset_busy", busy, 0);
    check("reset_done", load_done, 0);
    check("reset_strobes", {node_wen, leaf_wen, query_wen}, 0);
    check("reset_node_bus", {node_addr, node_dim, node_median}, 0);
    check("reset_leaf_bus", {leaf_addr, leaf_slot, leaf_wpatch}, 0);
    check("reset_query_bus", {query_addr, query_wpatch}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    build_image();

    run_load(0, 0, 1'b0, -1);
    check_table();
    run_load(30, 10, 1'b1, -1);
    run_load(0, 3, 1'b0, N_NODE_W + 1000);
    run_load(0, 2, 1'b0, -1);
    run_load(0, 0, 1'b0, -1);
    check_table();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
